uart_fifo_core: RTL and testbench

Parametrised successor to the single-byte UART core: full-duplex 8N1-class UART with configurable data width, stop bits and independent TX/RX FIFOs, plus sticky overrun and framing-error reporting. Sits between the RV32I GPIO/UART peripheral register block (bus side) and the TX/RX pins. Optional even-parity generation and checking is compiled in by macro.

---
 rtl/uart_fifo_core.sv | 212 +++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX/RX FIFOs and sticky overrun/framing/parity flags.
// Define UART_PARITY_EN to add an even-parity bit to every frame in both directions.
module uart_fifo_core #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_empty,
   output logic                 tx_busy,
   output logic                 TX,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_rd,
   output logic                 rx_valid,
   input  logic                 RX,
   input  logic                 rx_err_clr,
   output logic                 rx_overrun,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int BW   = $clog2(DATA_BITS + 1);
`ifdef UART_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [AW-1:0]        tx_wp, tx_rp;
   logic [AW:0]          tx_cnt;
   logic                 tx_push, tx_pop;
   logic [2:0]           tx_st;
   logic [CW-1:0]        tx_tmr;
   logic [BW-1:0]        tx_idx;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par, tx_tick, tx_end;

   assign tx_full  = tx_cnt == (AW+1)'(FIFO_DEPTH);
   assign tx_empty = tx_cnt == '0;
   assign tx_push  = tx_wr && !tx_full;
   assign tx_tick  = tx_tmr == '0;
   assign tx_end   = tx_st == S_STOP && tx_tick && tx_idx == BW'(STOP_BITS - 1);
   // Popping at the end of STOP chains the next frame with no idle gap.
   assign tx_pop   = (tx_st == S_IDLE || tx_end) && !tx_empty;
   assign tx_busy  = tx_st != S_IDLE;
   assign TX = tx_st == S_START ? 1'b0 :
               tx_st == S_DATA  ? tx_sh[0] :
               tx_st == S_PAR   ? tx_par : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wp] <= tx_data;
            tx_wp         <= tx_wp + 1'b1;
         end
         if (tx_pop) tx_rp <= tx_rp + 1'b1;
         tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st  <= S_IDLE;
         tx_tmr <= '0;
         tx_idx <= '0;
         tx_sh  <= '0;
         tx_par <= 1'b0;
      end else if (tx_pop) begin
         tx_st  <= S_START;
         tx_tmr <= CW'(CPB - 1);
         tx_idx <= '0;
         tx_sh  <= tx_mem[tx_rp];
         tx_par <= ^tx_mem[tx_rp];
      end else if (tx_end) begin
         tx_st <= S_IDLE;
      end else if (tx_st != S_IDLE) begin
         if (!tx_tick) begin
            tx_tmr <= tx_tmr - 1'b1;
         end else begin
            tx_tmr <= CW'(CPB - 1);
            tx_idx <= tx_idx + 1'b1;
            if (tx_st == S_START) begin
               tx_st  <= S_DATA;
               tx_idx <= '0;
            end else if (tx_st == S_DATA) begin
               tx_sh <= tx_sh >> 1;
               if (tx_idx == BW'(DATA_BITS - 1)) begin
                  tx_st  <= PAR_EN ? S_PAR : S_STOP;
                  tx_idx <= '0;
               end
            end else if (tx_st == S_PAR) begin
               tx_st  <= S_STOP;
               tx_idx <= '0;
            end
         end
      end
   end

   logic                 rx_s1, rx_s2, rx_s3;
   logic [2:0]           rx_st;
   logic [CW-1:0]        rx_tmr;
   logic [BW-1:0]        rx_idx;
   logic [DATA_BITS-1:0] rx_sh;
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]        rx_wp, rx_rp;
   logic [AW:0]          rx_cnt;
   logic                 rx_tick, rx_stop, rx_full, rx_push, rx_pop;

   assign rx_tick  = rx_tmr == '0;
   assign rx_stop  = rx_st == S_STOP && rx_tick;
   assign rx_full  = rx_cnt == (AW+1)'(FIFO_DEPTH);
   assign rx_valid = rx_cnt != '0;
   assign rx_pop   = rx_rd && rx_valid;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the frame.
   assign rx_push  = rx_stop && rx_s2 && (!rx_full || rx_pop);
   assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= RX;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_st  <= S_IDLE;
         rx_tmr <= '0;
         rx_idx <= '0;
         rx_sh  <= '0;
      end else if (rx_st == S_IDLE) begin
         if (rx_s3 && !rx_s2) begin
            rx_st  <= S_START;
            rx_tmr <= CW'(HALF - 1);
         end
      end else if (!rx_tick) begin
         rx_tmr <= rx_tmr - 1'b1;
      end else begin
         rx_tmr <= CW'(CPB - 1);
         rx_idx <= rx_idx + 1'b1;
         if (rx_st == S_START) begin
            rx_st  <= rx_s2 ? S_IDLE : S_DATA;
            rx_idx <= '0;
         end else if (rx_st == S_DATA) begin
            rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            if (rx_idx == BW'(DATA_BITS - 1)) rx_st <= PAR_EN ? S_PAR : S_STOP;
         end else if (rx_st == S_PAR) begin
            rx_st <= S_STOP;
         end else begin
            rx_st <= S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) begin
            rx_mem[rx_wp] <= rx_sh;
            rx_wp         <= rx_wp + 1'b1;
         end
         if (rx_pop) rx_rp <= rx_rp + 1'b1;
         rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_overrun   <= (rx_stop && rx_s2 && rx_full && !rx_pop) || (rx_overrun && !rx_err_clr);
         rx_frame_err <= (rx_stop && !rx_s2) || (rx_frame_err && !rx_err_clr);
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) rx_parity_err <= 1'b0;
      else rx_parity_err <= (rx_st == S_PAR && rx_tick && rx_s2 != ^rx_sh) || (rx_parity_err && !rx_err_clr);
   end
`else
   assign rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: scoreboard bench for uart_fifo_core at 16 clocks per bit.
// Loopback and bit-banged RX frames; UART_PARITY_EN adds the parity-error scenario.
module tb_uart_fifo_core;
   localparam int CPB = 16;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FRAME = (10 + PB) * CPB;

   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_wr = 1'b0, tx_full, tx_empty, tx_busy, TX;
   logic [7:0] rx_data;
   logic       rx_rd = 1'b0, rx_valid, RX, rx_err_clr = 1'b0;
   logic       rx_overrun, rx_frame_err, rx_parity_err;
   logic       loop = 1'b1, rx_drv = 1'b1, auto_rd = 1'b0;
   int         n_pass = 0, n_total = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;
   assign RX = loop ? TX : rx_drv;

   uart_fifo_core #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
      .tx_empty(tx_empty), .tx_busy(tx_busy), .TX(TX), .rx_data(rx_data), .rx_rd(rx_rd),
      .rx_valid(rx_valid), .RX(RX), .rx_err_clr(rx_err_clr), .rx_overrun(rx_overrun),
      .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: pops and compares every byte the RX FIFO presents while reading is enabled.
   initial forever begin
      @(negedge clk);
      rx_rd = 1'b0;
      if (auto_rd && rx_valid) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL rx_extra: got 0x%0h, expected no byte", rx_data);
         end else begin
            check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
         end
         rx_rd = 1'b1;
      end
   end

   task automatic wait_drain(input int lim);
      int i = 0;
      while (exp_q.size() != 0 && i < lim) begin
         @(negedge clk);
         i++;
      end
      check("rx_drain_left", 32'(exp_q.size()), 0);
   endtask

   task automatic burst(input logic [7:0] base, input logic push_exp);
      int b = 0;
      for (int i = 0; i < 6; i++) begin
         tx_data = 8'(base + i);
         tx_wr   = 1'b1;
         if (push_exp && i < 5) exp_q.push_back(8'(base + i));
         @(negedge clk);
         if (tx_busy) b++;
         if (i == 3) check("tx_not_full_3", 32'(tx_full), 0);
         if (i == 4) check("tx_full_4", 32'(tx_full), 1);
      end
      tx_wr = 1'b0;
      check("tx_full_drop", 32'(tx_full), 1);
      while (tx_busy && b < 4000) begin
         @(negedge clk);
         if (tx_busy) b++;
      end
      check("busy_cycles", b, 5 * FRAME);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      rx_drv = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rx_drv = par;
      repeat (CPB) @(negedge clk);
`else
      if (par === 1'bx) rx_drv = 1'b1;
`endif
      rx_drv = stop;
      repeat (CPB) @(negedge clk);
      rx_drv = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check("rst_TX", 32'(TX), 1);
      check("rst_busy", 32'(tx_busy), 0);
      check("rst_tx_empty", 32'(tx_empty), 1);
      check("rst_tx_full", 32'(tx_full), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_overrun", 32'(rx_overrun), 0);
      check("rst_frame_err", 32'(rx_frame_err), 0);
      check("rst_parity_err", 32'(rx_parity_err), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single loopback byte with cycle-exact TX start and RX latency window.
      auto_rd = 1'b1;
      tx_data = 8'h41;
      tx_wr   = 1'b1;
      exp_q.push_back(8'h41);
      @(negedge clk);
      tx_wr = 1'b0;
      check("tx_empty_n1", 32'(tx_empty), 0);
      check("TX_n1", 32'(TX), 1);
      @(negedge clk);
      check("TX_start_n2", 32'(TX), 0);
      check("busy_n2", 32'(tx_busy), 1);
      check("tx_empty_n2", 32'(tx_empty), 1);
      cyc = 2;
      while (!rx_valid && cyc < 600) begin
         @(negedge clk);
         cyc++;
      end
      check("rx_latency_in_window", 32'(cyc >= 152 + PB * CPB && cyc <= 160 + PB * CPB), 1);
      @(negedge clk);
      check("rx_valid_after_rd", 32'(rx_valid), 0);
      wait_drain(50);
      while (tx_busy) @(negedge clk);

      // Back-to-back burst: 5 accepted, sixth dropped, no idle gap.
      burst(8'h41, 1'b1);
      wait_drain(100);

      // Overrun: five frames into a four-deep RX FIFO with no reads.
      auto_rd = 1'b0;
      burst(8'h61, 1'b0);
      repeat (20) @(negedge clk);
      check("overrun_set", 32'(rx_overrun), 1);
      check("overrun_no_frame_err", 32'(rx_frame_err), 0);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h61 + i));
      auto_rd = 1'b1;
      wait_drain(50);
      repeat (3) @(negedge clk);
      check("overrun_fifth_dropped", 32'(rx_valid), 0);
      rx_err_clr = 1'b1;
      @(negedge clk);
      rx_err_clr = 1'b0;
      check("overrun_cleared", 32'(rx_overrun), 0);

      // Framing error: 0x55 with a low stop bit.
      loop = 1'b0;
      send_frame(8'h55, 1'b0, 1'b0);
      check("frame_err_set", 32'(rx_frame_err), 1);
      check("frame_err_no_push", 32'(rx_valid), 0);
      rx_err_clr = 1'b1;
      @(negedge clk);
      rx_err_clr = 1'b0;
      check("frame_err_cleared", 32'(rx_frame_err), 0);

      // Glitch shorter than half a bit must be rejected, then a good frame received.
      rx_drv = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_no_push", 32'(rx_valid), 0);
      check("glitch_no_err", 32'(rx_frame_err), 0);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1);
      wait_drain(50);
      check("good_parity_flag", 32'(rx_parity_err), 0);

`ifdef UART_PARITY_EN
      exp_q.push_back(8'h03);
      send_frame(8'h03, 1'b1, 1'b1);
      wait_drain(50);
      check("parity_err_set", 32'(rx_parity_err), 1);
`endif

      // Reset mid-frame.
      loop    = 1'b1;
      auto_rd = 1'b0;
      tx_data = 8'h33;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_data = 8'h34;
      @(negedge clk);
      tx_wr = 1'b0;
      repeat (50) @(negedge clk);
      check("pre_rst_busy", 32'(tx_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_TX", 32'(TX), 1);
      check("midrst_busy", 32'(tx_busy), 0);
      check("midrst_tx_empty", 32'(tx_empty), 1);
      check("midrst_rx_valid", 32'(rx_valid), 0);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("post_rst_rx_valid", 32'(rx_valid), 0);
      check("post_rst_TX", 32'(TX), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
